dec_scan_seq: RTL and testbench
===============================

Name: dec_scan_seq

Overview:
- Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder with active-high enable.
- Successor to the combinational 2-to-4 and 3-to-8 decoder blocks.
- Adds an auto-scan mode: an internal up/down index counter with load and wrap flag drives the decoder.
- Adds a parametrised minterm-select function output f, replacing hand-wired OR-of-outputs logic.
- Used for row/digit scanning and for sequenced select-line generation.

Parameters:
- SEL_W, 3, select/index width; the block has 2^SEL_W one-hot outputs (SEL_W >= 1).
- MINTERMS, 8'b1100_1000, 2^SEL_W-bit mask; f is the OR of the y bits whose MINTERMS bit is 1 (default gives f = y3|y6|y7).

Ports:
- clk  input  1  Single clock; all state updates on its rising edge.
- rst  input  1  Reset, synchronous, active-high.
- en  input  1  Decoder enable. When low, y is forced to 0 and stepping is frozen.
- mode  input  1  0 = direct decode of w; 1 = scan (decode the internal index).
- w  input  SEL_W  Direct-mode select, and the load value in scan mode.
- load  input  1  Load the index from w; effective in either mode.
- step  input  1  Advance the index by one; effective only when mode=1 and en=1.
- dir  input  1  Step direction: 0 = up, 1 = down.
- y  output  2^SEL_W  Registered one-hot (or all-zero) decode; bit k high means selection k.
- idx  output  SEL_W  Current internal index register.
- wrap  output  1  Registered one-cycle pulse on index wrap-around.
- f  output  1  Equals |(y & MINTERMS). Combinational from registered y, so it is cycle-aligned with y.

Behaviour:
- Reset (rst=1 at clock edge): idx=0, y=0, wrap=0, and therefore f=0. Reset overrides all other inputs, including load and step asserted in the same cycle.
- Next index, by priority:
  - load=1 → idx_next = w.
  - else if mode=1, en=1, step=1 → idx_next = idx+1 (dir=0) or idx-1 (dir=1), modulo 2^SEL_W.
  - else idx_next = idx.
- Wrap pulse:
  - wrap <= 1 only when a step is taken without load and either (dir=0 and idx = 2^SEL_W-1) or (dir=1 and idx=0).
  - Otherwise wrap <= 0; it is never held high for more than one cycle per step.
- Output register:
  - en=0 → y <= 0.
  - mode=0 → y <= onehot(w).
  - mode=1 → y <= onehot(idx_next).
  - Latency: one clock from the w/en/mode/load/step sample to y. In scan mode, y and idx update in the same cycle and always agree.
- Load is accepted regardless of en. With en=0, y stays 0, but idx takes the loaded value.
- Mode switching: idx is retained across mode changes. Direct mode never alters idx except through load.
- The block has no FSM beyond the index counter. Operating condition is (en, mode): disabled / direct / scan-hold / scan-step.
- Width rule: onehot(v) sets bit v only. Exactly one bit is high when en=1; zero bits are high when en=0.
- X on step or load while rst=1 must not propagate.

Test Plan:
- Reset: hold rst=1 for 2 cycles with en=1, mode=1, step=1, load=1, w=5 → y=8'h00, idx=0, wrap=0, f=0. After release, the first step gives y=8'h02, idx=1.
- Direct decode: en=1, mode=0.
  - w=3 → next cycle y=8'b0000_1000, f=1.
  - w=5 → y=8'b0010_0000, f=0.
  - w=7 → y=8'h80, f=1.
  - en=0 → y=8'h00, f=0, idx unchanged.
- Scan up with wrap: mode=1, en=1, load w=6, then step, dir=0, for 3 cycles → y bits 6,7,0,1 on successive cycles. wrap=1 only on the cycle y=8'h01. f = 1,1,0,0.
- Scan down and priority:
  - From idx=0, step with dir=1 → idx=7, y=8'h80, wrap=1.
  - load=1, w=2, with step=1 in the same cycle → idx=2, y=8'h04, wrap=0.
- Enable freeze: mode=1, en=0, step=1 for 4 cycles → idx constant, y=0, wrap=0. Then en=1 → y=onehot(idx).
- Reset mid-scan and parameter check:
  - rst pulsed during continuous stepping → idx=0, y=0 next cycle; stepping resumes at 1.
  - A second instance with SEL_W=2, MINTERMS=4'b1001 → scan sequence y=1,2,4,8,1, with f high at y=1 and y=8.

Source files
------------

// File: rtl/dec_scan_seq_if.sv
// Bundles the control inputs and decoded outputs of dec_scan_seq.
// The master side drives the controls, and the slave side is the decoder itself.
interface dec_scan_seq_if #(
  parameter int SEL_W = 3
);
  localparam int N = 2 ** SEL_W;

  logic             en;
  logic             mode;
  logic [SEL_W-1:0] w;
  logic             load;
  logic             step;
  logic             dir;
  logic [N-1:0]     y;
  logic [SEL_W-1:0] idx;
  logic             wrap;
  logic             f;

  modport master (
    output en, mode, w, load, step, dir,
    input  y, idx, wrap, f
  );

  modport slave (
    input  en, mode, w, load, step, dir,
    output y, idx, wrap, f
  );
endinterface

// File: rtl/dec_scan_seq.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with an auto-scan index counter.
// In direct mode the decoder decodes w. In scan mode it decodes the index that
// the counter is about to hold, so y and idx always agree.
// f is a minterm-select OR over the registered y.
module dec_scan_seq #(
  parameter int                    SEL_W    = 3,
  parameter logic [2**SEL_W-1:0]   MINTERMS = 8'b1100_1000
) (
  input  logic            clk,
  input  logic            rst,
  dec_scan_seq_if.slave   bus
);
  localparam int N = 2 ** SEL_W;
  localparam logic [SEL_W-1:0] IDX_ZERO = {SEL_W{1'b0}};
  localparam logic [SEL_W-1:0] IDX_MAX  = {SEL_W{1'b1}};
  localparam logic [SEL_W-1:0] IDX_ONE  = {{(SEL_W-1){1'b0}}, 1'b1};

  logic [SEL_W-1:0] idx_r;
  logic [N-1:0]     y_r;
  logic             wrap_r;

  logic             step_take_s;
  logic [SEL_W-1:0] idx_next_s;
  logic             wrap_next_s;
  logic [N-1:0]     y_next_s;

  // Build a vector with only bit v set.
  function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] v);
    logic [N-1:0] r;
    r    = {N{1'b0}};
    r[v] = 1'b1;
    return r;
  endfunction

  // A step counts only in scan mode with the decoder enabled.
  assign step_take_s = bus.mode & bus.en & bus.step;

  // Choose the next index. Load has priority over step, and a wrap is flagged only for a real step.
  always_comb begin
    idx_next_s  = idx_r;
    wrap_next_s = 1'b0;
    if (bus.load) begin
      idx_next_s  = bus.w;
      wrap_next_s = 1'b0;
    end else if (step_take_s) begin
      if (bus.dir) begin
        idx_next_s  = idx_r - IDX_ONE;
        wrap_next_s = (idx_r == IDX_ZERO);
      end else begin
        idx_next_s  = idx_r + IDX_ONE;
        wrap_next_s = (idx_r == IDX_MAX);
      end
    end else begin
      idx_next_s  = idx_r;
      wrap_next_s = 1'b0;
    end
  end

  // Choose the next decode for the operating condition (en, mode).
  always_comb begin
    y_next_s = {N{1'b0}};
    case ({bus.en, bus.mode})
      2'b10:   y_next_s = onehot(bus.w);
      2'b11:   y_next_s = onehot(idx_next_s);
      default: y_next_s = {N{1'b0}};
    endcase
  end

  // Index, decode and wrap registers. Reset overrides load and step.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r  <= IDX_ZERO;
      y_r    <= {N{1'b0}};
      wrap_r <= 1'b0;
    end else begin
      idx_r  <= idx_next_s;
      y_r    <= y_next_s;
      wrap_r <= wrap_next_s;
    end
  end

  assign bus.idx  = idx_r;
  assign bus.y    = y_r;
  assign bus.wrap = wrap_r;
  assign bus.f    = |(y_r & MINTERMS);
endmodule

// File: tb/tb_dec_scan_seq.sv
// Directed bench for dec_scan_seq. It drives two instances: the default SEL_W=3
// instance and a SEL_W=2, MINTERMS=4'b1001 instance. An abstract model runs
// alongside them, and a compare process checks both instances against it every cycle.
// Hand-computed literal checks pin the model.
module tb_dec_scan_seq;
  logic clk = 1'b0;
  logic rst;
  logic en, mode, load, step, dir;
  logic [2:0] w;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  // Model state for each instance. Index 0 is SEL_W=3 and index 1 is SEL_W=2.
  int m_idx  [2];
  int m_y    [2];
  bit m_wrap [2];

  dec_scan_seq_if #(.SEL_W(3)) bus_a ();
  dec_scan_seq_if #(.SEL_W(2)) bus_b ();

  assign bus_a.en = en;   assign bus_b.en = en;
  assign bus_a.mode = mode; assign bus_b.mode = mode;
  assign bus_a.load = load; assign bus_b.load = load;
  assign bus_a.step = step; assign bus_b.step = step;
  assign bus_a.dir = dir;  assign bus_b.dir = dir;
  assign bus_a.w = w;      assign bus_b.w = w[1:0];

  dec_scan_seq #(.SEL_W(3), .MINTERMS(8'b1100_1000)) u_a (
    .clk (clk), .rst (rst), .bus (bus_a.slave)
  );
  dec_scan_seq #(.SEL_W(2), .MINTERMS(4'b1001)) u_b (
    .clk (clk), .rst (rst), .bus (bus_b.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model that applies the block's rules with plain arithmetic.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int n;
      int wk;
      int nxt;
      bit taken;
      n  = (k == 0) ? 8 : 4;
      wk = int'(w) % n;
      if (rst) begin
        m_idx[k]  <= 0;
        m_y[k]    <= 0;
        m_wrap[k] <= 1'b0;
      end else begin
        taken = mode && en && step && !load;
        if (load) nxt = wk;
        else if (taken) nxt = dir ? (m_idx[k] + n - 1) % n : (m_idx[k] + 1) % n;
        else nxt = m_idx[k];
        m_wrap[k] <= taken && ((!dir && m_idx[k] == n - 1) || (dir && m_idx[k] == 0));
        m_idx[k]  <= nxt;
        m_y[k]    <= !en ? 0 : (mode ? (1 << nxt) : (1 << wk));
      end
    end
    started <= 1'b1;
  end

  // Compare both instances against the model on every falling edge.
  always @(negedge clk) begin
    if (started) begin
      chk("a_y",    32'(bus_a.y),    32'(m_y[0]));
      chk("a_idx",  32'(bus_a.idx),  32'(m_idx[0]));
      chk("a_wrap", 32'(bus_a.wrap), 32'(m_wrap[0]));
      chk("a_f",    32'(bus_a.f),    32'((m_y[0] & 8'hC8) != 0));
      chk("b_y",    32'(bus_b.y),    32'(m_y[1]));
      chk("b_idx",  32'(bus_b.idx),  32'(m_idx[1]));
      chk("b_wrap", 32'(bus_b.wrap), 32'(m_wrap[1]));
      chk("b_f",    32'(bus_b.f),    32'((m_y[1] & 4'h9) != 0));
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; mode = 1'b1; step = 1'b1; load = 1'b1; w = 3'd5; dir = 1'b0;
    cyc(); cyc();
    chk("rst_y", 32'(bus_a.y), 32'h00);
    chk("rst_idx", 32'(bus_a.idx), 32'd0);
    chk("rst_wrap", 32'(bus_a.wrap), 32'd0);
    chk("rst_f", 32'(bus_a.f), 32'd0);

    rst = 1'b0; load = 1'b0;
    cyc();
    chk("first_step_y", 32'(bus_a.y), 32'h02);
    chk("first_step_idx", 32'(bus_a.idx), 32'd1);

    // Direct decode.
    mode = 1'b0; step = 1'b0; w = 3'd3;
    cyc();
    chk("dir_w3_y", 32'(bus_a.y), 32'h08);
    chk("dir_w3_f", 32'(bus_a.f), 32'd1);
    w = 3'd5;
    cyc();
    chk("dir_w5_y", 32'(bus_a.y), 32'h20);
    chk("dir_w5_f", 32'(bus_a.f), 32'd0);
    w = 3'd7;
    cyc();
    chk("dir_w7_y", 32'(bus_a.y), 32'h80);
    chk("dir_w7_f", 32'(bus_a.f), 32'd1);
    en = 1'b0;
    cyc();
    chk("dis_y", 32'(bus_a.y), 32'h00);
    chk("dis_f", 32'(bus_a.f), 32'd0);
    chk("dis_idx", 32'(bus_a.idx), 32'd1);

    // Scan up through the wrap.
    en = 1'b1; mode = 1'b1; load = 1'b1; w = 3'd6;
    cyc();
    chk("load6_y", 32'(bus_a.y), 32'h40);
    chk("load6_f", 32'(bus_a.f), 32'd1);
    load = 1'b0; step = 1'b1; dir = 1'b0;
    cyc();
    chk("up7_y", 32'(bus_a.y), 32'h80);
    chk("up7_wrap", 32'(bus_a.wrap), 32'd0);
    chk("up7_f", 32'(bus_a.f), 32'd1);
    cyc();
    chk("up0_y", 32'(bus_a.y), 32'h01);
    chk("up0_wrap", 32'(bus_a.wrap), 32'd1);
    chk("up0_f", 32'(bus_a.f), 32'd0);
    cyc();
    chk("up1_y", 32'(bus_a.y), 32'h02);
    chk("up1_wrap", 32'(bus_a.wrap), 32'd0);

    // Scan down through the wrap, then load wins over step.
    step = 1'b0; load = 1'b1; w = 3'd0;
    cyc();
    chk("load0_idx", 32'(bus_a.idx), 32'd0);
    load = 1'b0; step = 1'b1; dir = 1'b1;
    cyc();
    chk("dn7_idx", 32'(bus_a.idx), 32'd7);
    chk("dn7_y", 32'(bus_a.y), 32'h80);
    chk("dn7_wrap", 32'(bus_a.wrap), 32'd1);
    load = 1'b1; w = 3'd2;
    cyc();
    chk("prio_idx", 32'(bus_a.idx), 32'd2);
    chk("prio_y", 32'(bus_a.y), 32'h04);
    chk("prio_wrap", 32'(bus_a.wrap), 32'd0);

    // Enable freeze.
    load = 1'b0; en = 1'b0; dir = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("frz_idx", 32'(bus_a.idx), 32'd2);
      chk("frz_y", 32'(bus_a.y), 32'h00);
      chk("frz_wrap", 32'(bus_a.wrap), 32'd0);
    end
    en = 1'b1; step = 1'b0;
    cyc();
    chk("unfrz_y", 32'(bus_a.y), 32'h04);

    // A load while disabled still updates idx.
    en = 1'b0; load = 1'b1; w = 3'd5;
    cyc();
    chk("dload_idx", 32'(bus_a.idx), 32'd5);
    chk("dload_y", 32'(bus_a.y), 32'h00);
    en = 1'b1; load = 1'b0;
    cyc();
    chk("dload_en_y", 32'(bus_a.y), 32'h20);

    // Reset in the middle of a scan.
    step = 1'b1;
    cyc(); cyc();
    chk("pre_rst_idx", 32'(bus_a.idx), 32'd7);
    rst = 1'b1;
    cyc();
    chk("mid_rst_idx", 32'(bus_a.idx), 32'd0);
    chk("mid_rst_y", 32'(bus_a.y), 32'h00);
    rst = 1'b0;
    cyc();
    chk("post_rst_idx", 32'(bus_a.idx), 32'd1);
    chk("post_rst_y", 32'(bus_a.y), 32'h02);

    // Scan sequence of the narrow instance.
    step = 1'b0; load = 1'b1; w = 3'd0;
    cyc();
    chk("b_seq0_y", 32'(bus_b.y), 32'h1);
    chk("b_seq0_f", 32'(bus_b.f), 32'd1);
    load = 1'b0; step = 1'b1; dir = 1'b0;
    cyc();
    chk("b_seq1_y", 32'(bus_b.y), 32'h2);
    chk("b_seq1_f", 32'(bus_b.f), 32'd0);
    cyc();
    chk("b_seq2_y", 32'(bus_b.y), 32'h4);
    chk("b_seq2_f", 32'(bus_b.f), 32'd0);
    cyc();
    chk("b_seq3_y", 32'(bus_b.y), 32'h8);
    chk("b_seq3_f", 32'(bus_b.f), 32'd1);
    cyc();
    chk("b_seq4_y", 32'(bus_b.y), 32'h1);
    chk("b_seq4_f", 32'(bus_b.f), 32'd1);
    chk("b_seq4_wrap", 32'(bus_b.wrap), 32'd1);

    step = 1'b0;
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
